// File: rtl/fifomult_driver.sv
// Transmit-side driver for the fifomult2024 multiplier. Operand pairs are buffered in a small FIFO,
// sent as two parity-protected words, and one response per pair is collected with a timeout.
module fifomult_driver #(
  parameter int DATA_W  = 16,
  parameter int RES_W   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              op_inj_err,
  input  logic              op_valid,
  output logic              op_ready,
  output logic [DATA_W-1:0] data_in,
  output logic              data_in_parity,
  output logic              data_in_valid,
  input  logic              busy_out,
  input  logic [RES_W-1:0]  data_out,
  input  logic              data_out_parity,
  input  logic              data_out_valid,
  input  logic              data_in_parity_error,
  output logic [RES_W-1:0]  res_data,
  output logic              res_valid,
  output logic              res_par_ok,
  output logic              err_pulse,
  output logic              timeout_pulse,
  output logic              idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              inj;
  } pair_t;

  typedef enum logic [1:0] {S_IDLE, S_SEND_B, S_WAIT} state_t;

  pair_t             mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              full, empty, push, pop;
  pair_t             head;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] data_in_q;
  logic              data_in_par_q, data_in_vld_q;
  logic [RES_W-1:0]  res_data_q;
  logic              res_vld_q, res_ok_q, err_q, to_q;

  // Extra pointer bit separates full from empty; ready depends only on registered pointers.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = op_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty && !busy_out;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{a: op_a, b: op_b, inj: op_inj_err};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      b_q           <= '0;
      data_in_q     <= '0;
      data_in_par_q <= 1'b0;
      data_in_vld_q <= 1'b0;
      res_data_q    <= '0;
      res_vld_q     <= 1'b0;
      res_ok_q      <= 1'b0;
      err_q         <= 1'b0;
      to_q          <= 1'b0;
    end else begin
      data_in_vld_q <= 1'b0;
      res_vld_q     <= 1'b0;
      err_q         <= 1'b0;
      to_q          <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            data_in_q     <= head.a;
            data_in_par_q <= (^head.a) ^ head.inj;
            data_in_vld_q <= 1'b1;
            b_q           <= head.b;
            state_q       <= S_SEND_B;
          end
        end
        S_SEND_B: begin
          if (!busy_out) begin
            data_in_q     <= b_q;
            data_in_par_q <= ^b_q;
            data_in_vld_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // A product and an error in the same cycle both get reported.
          if (data_out_valid || data_in_parity_error) begin
            if (data_out_valid) begin
              res_vld_q  <= 1'b1;
              res_data_q <= data_out;
              res_ok_q   <= ((^data_out) == data_out_parity);
            end
            err_q   <= data_in_parity_error;
            state_q <= S_IDLE;
          end else if (cnt_q == CW'(TIMEOUT-1)) begin
            to_q    <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign op_ready       = !full;
  assign idle           = empty && (state_q == S_IDLE);
  assign data_in        = data_in_q;
  assign data_in_parity = data_in_par_q;
  assign data_in_valid  = data_in_vld_q;
  assign res_data       = res_data_q;
  assign res_valid      = res_vld_q;
  assign res_par_ok     = res_ok_q;
  assign err_pulse      = err_q;
  assign timeout_pulse  = to_q;

endmodule

// File: tb/tb_fifomult_driver.sv
// Bench for fifomult_driver: a multiplier responder, a table of single-pair vectors,
// hand sequences for backpressure/full/timeout/reset, and a randomized run against a pair-level model.
module tb_fifomult_driver;
  localparam int DW = 16, RW = 32, DEPTH = 4, TO = 64;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] op_a = '0, op_b = '0;
  logic          op_inj_err = 1'b0, op_valid = 1'b0, op_ready;
  logic [DW-1:0] data_in;
  logic          data_in_parity, data_in_valid;
  logic          busy_out = 1'b0;
  logic [RW-1:0] data_out = '0;
  logic          data_out_parity = 1'b0, data_out_valid = 1'b0, data_in_parity_error = 1'b0;
  logic [RW-1:0] res_data;
  logic          res_valid, res_par_ok, err_pulse, timeout_pulse, idle;

  fifomult_driver #(.DATA_W(DW), .RES_W(RW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op_a(op_a), .op_b(op_b), .op_inj_err(op_inj_err),
    .op_valid(op_valid), .op_ready(op_ready), .data_in(data_in), .data_in_parity(data_in_parity),
    .data_in_valid(data_in_valid), .busy_out(busy_out), .data_out(data_out),
    .data_out_parity(data_out_parity), .data_out_valid(data_out_valid),
    .data_in_parity_error(data_in_parity_error), .res_data(res_data), .res_valid(res_valid),
    .res_par_ok(res_par_ok), .err_pulse(err_pulse), .timeout_pulse(timeout_pulse), .idle(idle));

  always #5 clk = ~clk;

  typedef enum int {M_OK, M_BADPAR, M_SILENT, M_BOTH} mode_e;
  typedef enum int {E_RES, E_ERR, E_TO} kind_e;
  typedef struct { kind_e k; logic [RW-1:0] d; logic ok; int cyc; } ev_t;
  typedef struct { logic [DW-1:0] d; logic p; int cyc; } wd_t;
  typedef struct {
    logic [DW-1:0] a, b; logic inj; mode_e m;
    logic pa, pb; kind_e k; logic [RW-1:0] r; logic ok; int nev;
  } vec_t;

  ev_t   evs[$], exp_e[$];
  wd_t   wds[$], exp_w[$];
  mode_e mode_q[$];
  int    cyc = 0, n_cmp = 0, n_fail = 0;
  logic          have_a = 1'b0, a_p = 1'b0;
  logic [DW-1:0] a_w = '0;
  bit            rand_busy = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Multiplier stand-in: checks A parity, answers one cycle after B in the requested style.
  task automatic respond(mode_e m, logic [DW-1:0] b);
    logic [RW-1:0] prod;
    prod = RW'(a_w) * RW'(b);
    case (m)
      M_SILENT: ;
      M_BOTH: begin
        data_out = prod; data_out_parity = ^prod; data_out_valid = 1'b1; data_in_parity_error = 1'b1;
      end
      default: begin
        if (a_p != ^a_w) data_in_parity_error = 1'b1;
        else begin
          data_out = prod; data_out_valid = 1'b1;
          data_out_parity = (m == M_BADPAR) ? ~(^prod) : ^prod;
        end
      end
    endcase
  endtask

  task automatic tick();
    mode_e m;
    @(posedge clk); #1;
    cyc++;
    data_out_valid = 1'b0; data_in_parity_error = 1'b0;
    if (res_valid)     evs.push_back('{E_RES, res_data, res_par_ok, cyc});
    if (err_pulse)     evs.push_back('{E_ERR, '0, 1'b0, cyc});
    if (timeout_pulse) evs.push_back('{E_TO, '0, 1'b0, cyc});
    if (data_in_valid) begin
      wds.push_back('{data_in, data_in_parity, cyc});
      if (!have_a) begin
        have_a = 1'b1; a_w = data_in; a_p = data_in_parity;
      end else begin
        have_a = 1'b0;
        m = (mode_q.size() > 0) ? mode_q.pop_front() : M_OK;
        respond(m, data_in);
      end
    end
    if (rand_busy) busy_out = ($urandom_range(0, 3) == 0);
  endtask

  task automatic push(logic [DW-1:0] a, logic [DW-1:0] b, logic inj, mode_e m, output int acc);
    int i = 0;
    op_a = a; op_b = b; op_inj_err = inj; op_valid = 1'b1;
    while (!op_ready && i < 1000) begin tick(); i++; end
    acc = -1;
    if (!op_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL push_wait: op_ready still %0b after %0d cycles", op_ready, i);
      op_valid = 1'b0;
      return;
    end
    mode_q.push_back(m);
    tick();
    acc = cyc;
    op_valid = 1'b0;
  endtask

  task automatic wait_ev(int n, int bound, string nm);
    int i = 0;
    while (evs.size() < n && i < bound) begin tick(); i++; end
    n_cmp++;
    if (evs.size() < n) begin
      n_fail++;
      $display("FAIL %s: %0d responses after %0d cycles, required %0d", nm, evs.size(), i, n);
    end
  endtask

  task automatic clear();
    wds.delete(); evs.delete(); mode_q.delete();
  endtask

  vec_t tbl[7];

  initial begin
    int acc, i;
    logic [DW-1:0] ra, rb;
    logic rinj;
    mode_e rm;
    int r;

    tbl[0] = '{16'h0007, 16'h0002, 1'b0, M_OK,     1'b1, 1'b1, E_RES, 32'h0000000E, 1'b1, 1};
    tbl[1] = '{16'h0003, 16'h0005, 1'b1, M_OK,     1'b1, 1'b0, E_ERR, 32'h0,        1'b0, 1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b0, M_OK,     1'b0, 1'b0, E_RES, 32'hFFFE0001, 1'b1, 1};
    tbl[3] = '{16'h0001, 16'h0001, 1'b0, M_BADPAR, 1'b1, 1'b1, E_RES, 32'h00000001, 1'b0, 1};
    tbl[4] = '{16'h1234, 16'h0000, 1'b0, M_OK,     1'b1, 1'b0, E_RES, 32'h0,        1'b1, 1};
    tbl[5] = '{16'h0001, 16'h0002, 1'b1, M_OK,     1'b0, 1'b1, E_ERR, 32'h0,        1'b0, 1};
    tbl[6] = '{16'h0002, 16'h0003, 1'b0, M_BOTH,   1'b1, 1'b0, E_RES, 32'h00000006, 1'b1, 2};

    // Reset state
    #22;
    chk("rst_outs", 64'({data_in, data_in_parity, data_in_valid, res_data, res_valid,
                         res_par_ok, err_pulse, timeout_pulse}), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(op_ready), 64'(1));
    chk("rst_idle", 64'(idle), 64'(1));

    // Table of single pairs
    foreach (tbl[v]) begin
      clear();
      push(tbl[v].a, tbl[v].b, tbl[v].inj, tbl[v].m, acc);
      wait_ev(tbl[v].nev, 100, $sformatf("t%0d_resp", v));
      chk($sformatf("t%0d_idle", v), 64'(idle), 64'(1));
      chk($sformatf("t%0d_nwords", v), 64'(wds.size()), 64'(2));
      chk($sformatf("t%0d_nev", v), 64'(evs.size()), 64'(tbl[v].nev));
      if (wds.size() == 2) begin
        chk($sformatf("t%0d_lat", v), 64'(wds[0].cyc - acc >= 1), 64'(1));
        chk($sformatf("t%0d_a", v), 64'({wds[0].d, wds[0].p}), 64'({tbl[v].a, tbl[v].pa}));
        chk($sformatf("t%0d_b", v), 64'({wds[1].d, wds[1].p}), 64'({tbl[v].b, tbl[v].pb}));
        chk($sformatf("t%0d_b2b", v), 64'(wds[1].cyc - wds[0].cyc), 64'(1));
      end
      if (evs.size() >= 1) begin
        chk($sformatf("t%0d_kind", v), 64'(evs[0].k), 64'(tbl[v].k));
        if (tbl[v].k == E_RES)
          chk($sformatf("t%0d_res", v), 64'({evs[0].d, evs[0].ok}), 64'({tbl[v].r, tbl[v].ok}));
      end
      if (tbl[v].nev == 2 && evs.size() == 2)
        chk($sformatf("t%0d_both", v), 64'({evs[1].k, evs[1].cyc}), 64'({E_ERR, evs[0].cyc}));
    end

    // Backpressure in SEND_B
    clear();
    push(16'h0007, 16'h0002, 1'b0, M_OK, acc);
    i = 0;
    while (wds.size() < 1 && i < 20) begin tick(); i++; end
    busy_out = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bp_hold%0d", k), 64'({data_in_valid, data_in}), 64'({1'b0, 16'h0007}));
    end
    busy_out = 1'b0;
    wait_ev(1, 20, "bp_resp");
    chk("bp_nwords", 64'(wds.size()), 64'(2));
    if (wds.size() == 2) begin
      chk("bp_b", 64'(wds[1].d), 64'(16'h0002));
      chk("bp_gap", 64'(wds[1].cyc - wds[0].cyc), 64'(4));
    end
    if (evs.size() >= 1) chk("bp_res", 64'(evs[0].d), 64'(32'hE));

    // FIFO full with busy held, fifth pair only after first pop
    clear();
    busy_out = 1'b1;
    for (int k = 0; k < 4; k++) push(DW'(2*k+1), DW'(2*k+2), 1'b0, M_OK, acc);
    chk("full_ready", 64'(op_ready), 64'(0));
    op_a = 16'd9; op_b = 16'd10; op_inj_err = 1'b0; op_valid = 1'b1;
    tick(); tick();
    chk("full_hold", 64'({op_ready, wds.size()}), 64'({1'b0, 32'd0}));
    busy_out = 1'b0;
    i = 0;
    while (!op_ready && i < 20) begin tick(); i++; end
    chk("full_after_pop", 64'(wds.size() >= 1), 64'(1));
    push(16'd9, 16'd10, 1'b0, M_OK, acc);
    wait_ev(5, 200, "full_resp");
    chk("full_nwords", 64'(wds.size()), 64'(10));
    for (int k = 0; k < 5 && k < evs.size(); k++)
      chk($sformatf("full_res%0d", k), 64'(evs[k].d), 64'((2*k+1)*(2*k+2)));
    for (int k = 0; k < 10 && k < wds.size(); k++)
      chk($sformatf("full_w%0d", k), 64'(wds[k].d), 64'(k+1));

    // Timeout, then a product with bad parity
    clear();
    push(16'd5, 16'd6, 1'b0, M_SILENT, acc);
    wait_ev(1, TO + 20, "to_resp");
    if (evs.size() >= 1 && wds.size() == 2) begin
      chk("to_kind", 64'(evs[0].k), 64'(E_TO));
      chk("to_time", 64'(evs[0].cyc - wds[1].cyc), 64'(TO));
    end
    clear();
    push(16'd1, 16'd1, 1'b0, M_BADPAR, acc);
    wait_ev(1, 20, "bad_resp");
    if (evs.size() >= 1) chk("bad_res", 64'({evs[0].k, evs[0].d, evs[0].ok}), 64'({E_RES, 32'd1, 1'b0}));

    // Reset during WAIT, then a late response
    clear();
    push(16'd9, 16'd9, 1'b0, M_SILENT, acc);
    i = 0;
    while (wds.size() < 2 && i < 20) begin tick(); i++; end
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 64'({data_in, data_in_parity, data_in_valid, res_data, res_valid,
                             res_par_ok, err_pulse, timeout_pulse}), 64'(0));
    have_a = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_idle", 64'({idle, op_ready}), 64'(2'b11));
    clear();
    data_out = 32'h51; data_out_parity = 1'b1; data_out_valid = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("late_resp_ignored", 64'({evs.size(), wds.size()}), 64'(0));

    // Randomized pairs against the pair-level model
    clear(); exp_w.delete(); exp_e.delete();
    rand_busy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      ra = DW'($urandom); rb = DW'($urandom);
      rinj = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 19);
      rm = (r == 0) ? M_SILENT : (r < 5) ? M_BADPAR : M_OK;
      push(ra, rb, rinj, rm, acc);
      exp_w.push_back('{ra, (^ra) ^ rinj, 0});
      exp_w.push_back('{rb, ^rb, 0});
      if (rm == M_SILENT)  exp_e.push_back('{E_TO, '0, 1'b0, 0});
      else if (rinj)       exp_e.push_back('{E_ERR, '0, 1'b0, 0});
      else                 exp_e.push_back('{E_RES, RW'(ra) * RW'(rb), rm == M_OK, 0});
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
    wait_ev(40, 8000, "rnd_resp");
    rand_busy = 1'b0; busy_out = 1'b0;
    tick();
    chk("rnd_nwords", 64'(wds.size()), 64'(exp_w.size()));
    chk("rnd_nev", 64'(evs.size()), 64'(exp_e.size()));
    for (int k = 0; k < wds.size() && k < exp_w.size(); k++)
      chk($sformatf("rnd_w%0d", k), 64'({wds[k].d, wds[k].p}), 64'({exp_w[k].d, exp_w[k].p}));
    for (int k = 0; k < evs.size() && k < exp_e.size(); k++)
      chk($sformatf("rnd_e%0d", k), 64'({evs[k].k, evs[k].d, evs[k].ok}),
          64'({exp_e[k].k, exp_e[k].d, exp_e[k].ok}));
    chk("rnd_idle", 64'(idle), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifomult_driver.md
Name: fifomult_driver

Overview:
- Transmit-side companion of the fifomult2024 multiplier.
- Accepts operand pairs on a valid/ready interface and buffers them in a small FIFO.
- Serialises each pair onto the multiplier input stream (data_in, data_in_parity, data_in_valid) and honours busy_out.
- Collects the returning product or parity-error response, with one pair in flight at a time. Used as a reusable stimulus engine and as an integration front-end.

Parameters:
- DATA_W, 16, operand width (width of data_in).
- RES_W, 32, result width (width of data_out).
- DEPTH, 4, operand-pair FIFO entries; power of 2, at least 2.
- TIMEOUT, 64, cycles to wait for a response before abandoning the pair.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_a  input  DATA_W  first operand.
- op_b  input  DATA_W  second operand.
- op_inj_err  input  1  corrupt the parity of op_a for this pair.
- op_valid  input  1  operand pair offered.
- op_ready  output  1  FIFO not full.
- data_in  output  DATA_W  word to the multiplier.
- data_in_parity  output  1  even parity of data_in.
- data_in_valid  output  1  word strobe, one cycle per word.
- busy_out  input  1  multiplier busy.
- data_out  input  RES_W  product from the multiplier.
- data_out_parity  input  1  parity of data_out.
- data_out_valid  input  1  product strobe.
- data_in_parity_error  input  1  multiplier reports an input parity error.
- res_data  output  RES_W  captured product.
- res_valid  output  1  one-cycle pulse with res_data.
- res_par_ok  output  1  ^data_out == data_out_parity; valid with res_valid.
- err_pulse  output  1  one-cycle pulse when the multiplier reports an input parity error.
- timeout_pulse  output  1  one-cycle pulse when no response arrives within TIMEOUT.
- idle  output  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FIFO cleared; FSM to IDLE; timeout counter 0.
  - Outputs: data_in=0, data_in_parity=0, data_in_valid=0, res_data=0, res_valid=0, res_par_ok=0, err_pulse=0, timeout_pulse=0.
  - op_ready=1 and idle=1 from the first cycle after reset release.
  - Reset mid-transfer discards the in-flight pair. Responses arriving after release while in IDLE are ignored.
- FIFO:
  - Push when op_valid && op_ready. Each entry stores {op_a, op_b, op_inj_err}.
  - op_ready = !full. A pop in the same cycle does not raise op_ready; no combinational path from pop to op_ready.
  - No bypass. A pair accepted in cycle N gives data_in_valid no earlier than N+2.
  - Pointers wrap modulo DEPTH.
- Parity: data_in_parity = ^data_in (even). For op_a with inj_err=1 it is ~(^op_a). op_b parity is always correct.
- FSM states:
  - IDLE: if the FIFO is not empty and busy_out=0, pop, drive A (data_in_valid=1) and go to SEND_B. If busy_out=1, hold.
  - SEND_B: if busy_out=0, drive B and go to WAIT. If busy_out=1, data_in_valid=0 and hold; B is never dropped.
  - WAIT: counter increments each cycle.
    - data_out_valid: res_valid=1, res_data=data_out, res_par_ok computed; go to IDLE.
    - else data_in_parity_error: err_pulse=1; go to IDLE.
    - else counter == TIMEOUT-1: timeout_pulse=1; go to IDLE.
    - Simultaneous data_out_valid and data_in_parity_error: both pulses fire; go to IDLE.
- Handshake rules:
  - data_in_valid is registered and never high on consecutive cycles unless A and B are sent back-to-back.
  - data_in holds its last value when data_in_valid=0.
  - busy_out is sampled in the cycle the word is launched.
- Throughput: minimum 4 cycles per pair (A, B, 1-cycle response, IDLE launch).
- Responses in IDLE or SEND_B are ignored, with no pulses.

Test Plan:
- Basic pair: push A=0x0007, B=0x0002, busy_out=0 -> data_in 0x0007 with parity 1, then 0x0002 with parity 1, on consecutive cycles. Model returns data_out=0x0000000E with parity 1 -> res_valid one cycle, res_data=0x0E, res_par_ok=1, idle=1.
- Backpressure: busy_out=1 for 3 cycles while in SEND_B -> data_in_valid low for 3 cycles, then B=0x0002 sent once; no duplicate or lost word.
- Injected error: A=0x0003 with op_inj_err=1 -> data_in_parity=1 for A. Model asserts data_in_parity_error -> err_pulse=1, res_valid stays 0.
- FIFO full: push 5 pairs back-to-back with busy_out=1 -> op_ready=0 after the 4th accept. Release busy_out -> all 4 pairs sent in order; the 5th is accepted only after the first pop.
- Timeout plus bad result parity: no response -> timeout_pulse in the 64th WAIT cycle. Next pair returns data_out=0x1, parity 0 -> res_par_ok=0.
- Reset mid-WAIT: drop rst_n -> all outputs 0 immediately. After release, a late data_out_valid produces no res_valid.
